// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and helpers shared by the ID/EX stage and its forwarding
// muxes.
//   - ALUFun encodings (6-bit). ALU_ADD is 0, so the all-zero bubble encoding
//     is a harmless add.
//   - Operand-select constants for the A and B ALU inputs.
//   - REG_ZERO: the hard-wired zero register. It is never forwarded and never
//     causes a hazard.
package cpu_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic ASEL_RS    = 1'b0;
  localparam logic ASEL_SHAMT = 1'b1;
  localparam logic BSEL_RT    = 1'b0;
  localparam logic BSEL_IMM   = 1'b1;

  typedef enum logic [5:0] {
    ALU_ADD = 6'b000000,
    ALU_SUB = 6'b000001,
    ALU_AND = 6'b011000,
    ALU_OR  = 6'b011110,
    ALU_XOR = 6'b010110,
    ALU_NOR = 6'b010001,
    ALU_A   = 6'b011010,
    ALU_SLL = 6'b100000,
    ALU_SRL = 6'b100001,
    ALU_SRA = 6'b100011,
    ALU_EQ  = 6'b110011,
    ALU_NEQ = 6'b110001,
    ALU_LT  = 6'b110101
  } alufun_e;

  localparam logic [5:0] ALUFUN_BUBBLE = 6'(ALU_ADD);

  // Producer (we, rd) writes the register that src names.
  function automatic logic fwd_hit(input logic we, input logic [4:0] rd,
                                   input logic [4:0] src);
    return we && (rd != REG_ZERO) && (rd == src);
  endfunction

  // Consumer source (used, src) depends on the producer destination rd.
  function automatic logic src_dep(input logic used, input logic [4:0] src,
                                   input logic [4:0] rd);
    return used && (rd != REG_ZERO) && (src == rd);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: selects the freshest value of one source register for the EX stage.
// Priority: EX/MEM producer, then MEM/WB producer, then the data captured from
// the register file. Register 0 never matches.
// Ports:
//   src           source register number held in EX
//   reg_data      register-file data captured with the instruction
//   mem_regwrite  EX/MEM producer write enable
//   mem_rd        EX/MEM producer destination register
//   mem_result    EX/MEM producer result
//   wb_regwrite   MEM/WB producer write enable
//   wb_rd         MEM/WB producer destination register
//   wb_result     MEM/WB producer result
//   value         forwarded operand
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        src,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_regwrite,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] value
);

  always_comb begin
    value = reg_data;
    if (fwd_hit(mem_regwrite, mem_rd, src)) begin
      value = mem_result;
    end else if (fwd_hit(wb_regwrite, wb_rd, src)) begin
      value = wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use
// hazard detection.
//
// Build option: define FORWARD_EN to forward from the MEM and WB stages.
//   - With FORWARD_EN, only a load in EX whose destination feeds a used ID
//     source stalls.
//   - Without FORWARD_EN, the captured register data is used as is. ID then
//     stalls on any used source that an in-flight EX or MEM writer targets.
//     A WB writer needs no stall because the register file writes before it
//     reads.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   id_*                 decoded instruction from ID
//   flush                kill the instruction entering EX
//   mem_regwrite/rd/result, wb_regwrite/rd/result   downstream producers
//   ex_a, ex_b           ALU operands (combinational, forwarded)
//   ex_store_data        forwarded rt value for stores
//   ex_alufun, ex_sign   ALU controls
//   ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_rd   EX controls
//   id_stall             combinational; ID/IF hold while high
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic              id_asel,
  input  logic              id_bsel,
  input  logic [5:0]        id_alufun,
  input  logic              id_sign,
  input  logic [4:0]        id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              flush,
  input  logic              mem_regwrite,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [5:0]        ex_alufun,
  output logic              ex_sign,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [4:0]        ex_rd,
  output logic              id_stall
);

`ifdef FORWARD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              sign;
    logic              asel;
    logic              bsel;
    logic [4:0]        rd;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        shamt;
    logic [5:0]        alufun;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } ex_state_t;

  ex_state_t         ex_q;
  ex_state_t         ex_d;
  logic              bubble;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // The ID instruction reads a source that the given producer writes.
  function automatic logic id_reads(input logic [4:0] rd);
    return id_valid && (src_dep(id_use_rs, id_rs, rd) || src_dep(id_use_rt, id_rt, rd));
  endfunction

`ifdef FORWARD_EN
  assign id_stall = ex_q.valid && ex_q.memread && id_reads(ex_q.rd);
`else
  assign id_stall = (ex_q.valid && ex_q.regwrite && id_reads(ex_q.rd)) ||
                    (mem_regwrite && id_reads(mem_rd));
`endif

  // A bubble is a fully cleared EX state. Invalid ID instructions are
  // captured the same way, so bubbles never leak stale controls.
  assign bubble = flush || id_stall || !id_valid;

  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.valid    = 1'b1;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.memwrite = id_memwrite;
      ex_d.sign     = id_sign;
      ex_d.asel     = id_asel;
      ex_d.bsel     = id_bsel;
      ex_d.rd       = id_rd;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
      ex_d.shamt    = id_shamt;
      ex_d.alufun   = id_alufun;
      ex_d.rs_data  = id_rs_data;
      ex_d.rt_data  = id_rt_data;
      ex_d.imm      = id_imm;
    end else begin
      ex_d.alufun = ALUFUN_BUBBLE;
      ex_d.rd     = REG_ZERO;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // With forwarding disabled the write enables are tied low, so both muxes
  // pass the captured register data straight through.
  fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs (
    .src          (ex_q.rs),
    .reg_data     (ex_q.rs_data),
    .mem_regwrite (mem_regwrite & FWD_ON),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite & FWD_ON),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .value        (fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W)) u_fwd_rt (
    .src          (ex_q.rt),
    .reg_data     (ex_q.rt_data),
    .mem_regwrite (mem_regwrite & FWD_ON),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite & FWD_ON),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .value        (fwd_rt)
  );

  assign ex_a          = (ex_q.asel == ASEL_SHAMT) ? {{(DATA_W-5){1'b0}}, ex_q.shamt} : fwd_rs;
  assign ex_b          = (ex_q.bsel == BSEL_IMM) ? ex_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_alufun     = ex_q.alufun;
  assign ex_sign       = ex_q.sign;
  assign ex_valid      = ex_q.valid;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_rd         = ex_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
module tb_id_ex_stage;
  import cpu_pkg::*;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs, id_use_rt, id_asel, id_bsel, id_sign;
  logic [4:0]  id_rs, id_rt, id_shamt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [5:0]  id_alufun;
  logic        id_regwrite, id_memread, id_memwrite, flush;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [5:0]  ex_alufun;
  logic        ex_sign, ex_valid, ex_regwrite, ex_memread, ex_memwrite, id_stall;
  logic [4:0]  ex_rd;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_asel(id_asel), .id_bsel(id_bsel),
    .id_alufun(id_alufun), .id_sign(id_sign), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_a(ex_a), .ex_b(ex_b), .ex_alufun(ex_alufun), .ex_sign(ex_sign),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_rd(ex_rd),
    .id_stall(id_stall)
  );

  typedef struct packed {
    logic        valid, use_rs, use_rt, asel, bsel, sign, regwrite, memread, memwrite;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  alufun;
    logic [31:0] imm, res;
  } instr_t;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2;

  // Reference machine: a small in-order pipeline (EX, MEM, WB) plus a physical
  // register file (written at WB) and an architectural one (updated in program
  // order when an instruction enters EX).
  instr_t      ex_m, mem_m, wb_m;
  logic [31:0] ex_rs_val, ex_rt_val;
  logic [31:0] arch [32];
  logic [31:0] phys [32];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input int kind, input logic [4:0] rs, input logic urs,
                                input logic [4:0] rt, input logic urt,
                                input logic [4:0] rd, input logic [31:0] res);
    instr_t r;
    r = '0;
    r.valid = 1'b1;
    r.rs = rs; r.use_rs = urs; r.rt = rt; r.use_rt = urt; r.rd = rd; r.res = res;
    r.imm = $urandom; r.shamt = 5'($urandom); r.alufun = 6'(ALU_OR); r.sign = 1'b1;
    r.regwrite = (kind != K_STORE);
    r.memread  = (kind == K_LOAD);
    r.memwrite = (kind == K_STORE);
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r = mk(int'($urandom_range(0, 2)), 5'($urandom_range(0, 7)), 1'($urandom),
           5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    r.valid  = ($urandom_range(0, 9) != 0);
    r.asel   = ($urandom_range(0, 3) == 0);
    r.bsel   = 1'($urandom);
    r.sign   = 1'($urandom);
    r.alufun = 6'($urandom);
    return r;
  endfunction

  // Register read with write-before-read from the instruction in WB.
  function automatic logic [31:0] rf_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_m.valid && wb_m.regwrite && wb_m.rd == r) return wb_m.res;
    return phys[r];
  endfunction

  function automatic logic needs(input instr_t i, input instr_t p);
    return p.valid && p.regwrite && p.rd != 5'd0 &&
           ((i.use_rs && i.rs == p.rd) || (i.use_rt && i.rt == p.rd));
  endfunction

  function automatic logic model_stall(input instr_t i);
    if (!i.valid) return 1'b0;
`ifdef FORWARD_EN
    return ex_m.memread && needs(i, ex_m);
`else
    return needs(i, ex_m) || needs(i, mem_m);
`endif
  endfunction

  task automatic drive_id(input instr_t i, input logic fl);
    id_valid = i.valid; id_rs = i.rs; id_rt = i.rt;
    id_use_rs = i.use_rs; id_use_rt = i.use_rt;
    id_rs_data = rf_read(i.rs); id_rt_data = rf_read(i.rt);
    id_imm = i.imm; id_shamt = i.shamt; id_asel = i.asel; id_bsel = i.bsel;
    id_alufun = i.alufun; id_sign = i.sign; id_rd = i.rd;
    id_regwrite = i.regwrite; id_memread = i.memread; id_memwrite = i.memwrite;
    flush = fl;
  endtask

  // A load in MEM only has its address, so its mem_result is deliberately
  // not the loaded value; stages without a writer present random rd/result.
  task automatic drive_back();
    mem_regwrite = mem_m.valid & mem_m.regwrite;
    mem_rd       = mem_m.valid ? mem_m.rd : 5'($urandom_range(0, 7));
    mem_result   = mem_m.valid ? (mem_m.memread ? (mem_m.res ^ 32'hA5A5_0F0F) : mem_m.res)
                               : $urandom;
    wb_regwrite  = wb_m.valid & wb_m.regwrite;
    wb_rd        = wb_m.valid ? wb_m.rd : 5'($urandom_range(0, 7));
    wb_result    = wb_m.valid ? wb_m.res : $urandom;
  endtask

  task automatic advance(input instr_t i, input logic fl, input logic stl);
    if (wb_m.valid && wb_m.regwrite && wb_m.rd != 5'd0) phys[wb_m.rd] = wb_m.res;
    wb_m  = mem_m;
    mem_m = ex_m;
    if (fl || stl || !i.valid) begin
      ex_m = '0;
    end else begin
      ex_m = i;
      ex_rs_val = arch[i.rs];
      ex_rt_val = arch[i.rt];
      if (i.regwrite && i.rd != 5'd0) arch[i.rd] = i.res;
    end
  endtask

  task automatic check_cycle(input logic exp_stall);
    chk("id_stall", 32'(id_stall), 32'(exp_stall));
    chk("ex_valid", 32'(ex_valid), 32'(ex_m.valid));
    chk("ex_regwrite", 32'(ex_regwrite), 32'(ex_m.regwrite));
    chk("ex_memread", 32'(ex_memread), 32'(ex_m.memread));
    chk("ex_memwrite", 32'(ex_memwrite), 32'(ex_m.memwrite));
    chk("ex_rd", 32'(ex_rd), 32'(ex_m.rd));
    chk("ex_alufun", 32'(ex_alufun), 32'(ex_m.alufun));
    if (ex_m.valid) begin
      chk("ex_sign", 32'(ex_sign), 32'(ex_m.sign));
      if (ex_m.asel) chk("ex_a_shamt", ex_a, {27'd0, ex_m.shamt});
      else if (ex_m.use_rs) chk("ex_a_rs", ex_a, ex_rs_val);
      if (ex_m.bsel) chk("ex_b_imm", ex_b, ex_m.imm);
      else if (ex_m.use_rt) chk("ex_b_rt", ex_b, ex_rt_val);
      if (ex_m.use_rt) chk("ex_store_data", ex_store_data, ex_rt_val);
    end
  endtask

  // Present one instruction until EX accepts it (or it is flushed).
  task automatic issue(input instr_t i, input logic fl, output int dut_stalls);
    logic exp_stall;
    dut_stalls = 0;
    for (int n = 0; n < 6; n++) begin
      drive_id(i, fl);
      @(negedge clk);
      exp_stall = model_stall(i);
      if (id_stall === 1'b1) dut_stalls++;
      check_cycle(exp_stall);
      @(posedge clk);
      advance(i, fl, exp_stall);
      #1;
      drive_back();
      if (fl || !exp_stall) return;
    end
    vectors++;
    miscompares++;
    $error("FAIL issue_bound: observed still stalled expected accepted");
  endtask

  task automatic clear_model();
    ex_m = '0; mem_m = '0; wb_m = '0;
    for (int r = 0; r < 32; r++) begin
      arch[r] = 32'd0;
      phys[r] = 32'd0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 0);
    chk({tag, "_regwrite"}, 32'(ex_regwrite), 0);
    chk({tag, "_memread"}, 32'(ex_memread), 0);
    chk({tag, "_memwrite"}, 32'(ex_memwrite), 0);
    chk({tag, "_rd"}, 32'(ex_rd), 0);
    chk({tag, "_alufun"}, 32'(ex_alufun), 0);
    chk({tag, "_sign"}, 32'(ex_sign), 0);
    chk({tag, "_a"}, ex_a, 0);
    chk({tag, "_b"}, ex_b, 0);
    chk({tag, "_store"}, ex_store_data, 0);
    chk({tag, "_stall"}, 32'(id_stall), 0);
  endtask

  initial begin
    instr_t c;
    int     s;

    clear_model();
    reset = 1'b1;
    drive_id('0, 1'b0);
    mem_regwrite = 1'b0; mem_rd = 5'd0; mem_result = 32'd0;
    wb_regwrite = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
    #2 reset = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    advance('0, 1'b0, 1'b0);
    #1 drive_back();

    // add r8 = 5, then a reader of r8
    issue(mk(K_ALU, 5'd1, 1'b0, 5'd2, 1'b0, 5'd8, 32'h5), 1'b0, s);
    issue(mk(K_ALU, 5'd8, 1'b1, 5'd3, 1'b0, 5'd4, 32'h77), 1'b0, s);
    chk("raw_ex_a", ex_a, 32'h5);
    chk("raw_stalls", 32'(s), FWD ? 0 : 2);

    // two writers of r9; the younger (in MEM) wins
    issue(mk(K_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 32'hB), 1'b0, s);
    issue(mk(K_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 32'hA), 1'b0, s);
    issue(mk(K_ALU, 5'd1, 1'b0, 5'd9, 1'b1, 5'd5, 32'h1), 1'b0, s);
    chk("mem_priority_b", ex_b, 32'hA);

    // load-use on rt
    issue(mk(K_LOAD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 32'h1234_5678), 1'b0, s);
    issue(mk(K_STORE, 5'd1, 1'b0, 5'd10, 1'b1, 5'd0, 32'h0), 1'b0, s);
    chk("load_use_stalls", 32'(s), FWD ? 1 : 2);
    chk("load_use_b", ex_b, 32'h1234_5678);
    chk("load_use_store", ex_store_data, 32'h1234_5678);

    // writer of r0 must never be seen
    issue(mk(K_ALU, 5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 32'hFFFF), 1'b0, s);
    issue(mk(K_ALU, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 32'h2), 1'b0, s);
    chk("r0_stalls", 32'(s), 0);
    chk("r0_a", ex_a, 32'd0);
    chk("r0_b", ex_b, 32'd0);

    // flush during a load-use stall
    issue(mk(K_LOAD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 32'hCAFE), 1'b0, s);
    issue(mk(K_ALU, 5'd11, 1'b1, 5'd0, 1'b0, 5'd7, 32'h3), 1'b1, s);
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_regwrite", 32'(ex_regwrite), 0);

    // reset in the middle of a stall
    issue(mk(K_LOAD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 32'hBEEF), 1'b0, s);
    c = mk(K_ALU, 5'd12, 1'b1, 5'd12, 1'b1, 5'd3, 32'h4);
    drive_id(c, 1'b0);
    @(negedge clk);
    chk("pre_reset_stall", 32'(id_stall), 1);
    #2 reset = 1'b0;
    #1 chk_all_zero("mid_reset");
    clear_model();
    id_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    advance('0, 1'b0, 1'b0);
    #1 drive_back();

    for (int n = 0; n < 300; n++) begin
      issue(rand_instr(), ($urandom_range(0, 9) == 0), s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
